// File: rtl/ff_bank_pkg.sv
// Shared mode/policy encodings and the single-channel next-state function
// for the multi-mode flip-flop bank.
package ff_bank_pkg;

   localparam logic [1:0] MODE_SR = 2'b00;
   localparam logic [1:0] MODE_JK = 2'b01;
   localparam logic [1:0] MODE_D  = 2'b10;
   localparam logic [1:0] MODE_T  = 2'b11;

   localparam logic [1:0] POL_HOLD = 2'b00;
   localparam logic [1:0] POL_SET  = 2'b01;
   localparam logic [1:0] POL_RST  = 2'b10;
   localparam logic [1:0] POL_TOG  = 2'b11;

   // Next state of one channel for an enabled, non-load cycle.
   function automatic logic ff_next(input logic [1:0] mode, input logic [1:0] pol,
                                    input logic a, input logic b, input logic q);
      logic nq;
      nq = q;
      case (mode)
         MODE_SR: begin
            case ({a, b})
               2'b01:   nq = 1'b0;
               2'b10:   nq = 1'b1;
               2'b11: begin
                  case (pol)
                     POL_SET: nq = 1'b1;
                     POL_RST: nq = 1'b0;
                     POL_TOG: nq = ~q;
                     default: nq = q;
                  endcase
               end
               default: nq = q;
            endcase
         end
         MODE_JK: begin
            case ({a, b})
               2'b01:   nq = 1'b0;
               2'b10:   nq = 1'b1;
               2'b11:   nq = ~q;
               default: nq = q;
            endcase
         end
         MODE_D:  nq = a;
         default: nq = a ? ~q : q;
      endcase
      return nq;
   endfunction

endpackage

// File: rtl/ff_bank_cell.sv
// One flip-flop channel: state bit, mode register, next-state mux and
// registered S=R=1 flag.
module ff_bank_cell
   import ff_bank_pkg::*;
#(
   parameter logic INIT_BIT = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       ld,
   input  logic       ld_val,
   input  logic       a,
   input  logic       b,
   input  logic       mode_wr,
   input  logic [1:0] mode_in,
   input  logic [1:0] sr_policy,
   output logic       q,
   output logic       illegal,
   output logic       illegal_set_c
);

   logic [1:0] mode;

   // Raised for the edge at which this channel sees an illegal SR sample.
   assign illegal_set_c = en & ~ld & (mode == MODE_SR) & a & b;

   // Mode update is concurrent with evaluation, so en uses the old mode.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q       <= INIT_BIT;
         mode    <= MODE_SR;
         illegal <= 1'b0;
      end else begin
         if (mode_wr) mode <= mode_in;
         if (ld)      q <= ld_val;
         else if (en) q <= ff_next(mode, sr_policy, a, b, q);
         illegal <= illegal_set_c;
      end
   end

endmodule

// File: rtl/multi_mode_ff_bank.sv
// Bank of WIDTH independently configurable SR/JK/D/T channels with load,
// enable, SR conflict policy and a saturating illegal-cycle counter.
module multi_mode_ff_bank
   import ff_bank_pkg::*;
#(
   parameter int unsigned      WIDTH = 8,
   parameter int unsigned      CNT_W = 4,
   parameter logic [WIDTH-1:0] INIT  = '0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               ld,
   input  logic [WIDTH-1:0]   ld_val,
   input  logic               mode_wr,
   input  logic [2*WIDTH-1:0] mode_in,
   input  logic [1:0]         sr_policy,
   input  logic               err_clr,
   output logic [WIDTH-1:0]   q,
   output logic [WIDTH-1:0]   q_bar,
   output logic [WIDTH-1:0]   illegal,
   output logic [CNT_W-1:0]   err_cnt
);

   logic [WIDTH-1:0] set_c;
   logic             any_set_c;

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      ff_bank_cell #(
         .INIT_BIT (INIT[i])
      ) u_cell (
         .clk           (clk),
         .rst_n         (rst_n),
         .en            (en),
         .ld            (ld),
         .ld_val        (ld_val[i]),
         .a             (a[i]),
         .b             (b[i]),
         .mode_wr       (mode_wr),
         .mode_in       (mode_in[2*i+1 -: 2]),
         .sr_policy     (sr_policy),
         .q             (q[i]),
         .illegal       (illegal[i]),
         .illegal_set_c (set_c[i])
      );
   end

   assign q_bar     = ~q;
   assign any_set_c = |set_c;

   // One count per offending edge; clear beats a same-edge increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         err_cnt <= '0;
      else if (err_clr)
         err_cnt <= '0;
      else if (any_set_c && (err_cnt != {CNT_W{1'b1}}))
         err_cnt <= err_cnt + CNT_W'(1);
   end

endmodule
